riscmakers_dcache_mem_bridge: RTL
=================================

Name: riscmakers_dcache_mem_bridge

Overview:
- Sits directly downstream of the RISC Makers bypassing data cache and serves its memory request/return channel.
- Converts each dcache memory request into one or more beats on a simple single-outstanding 64-bit memory bus.
- Returns one dcache return packet per accepted request: a load ACK carrying line-formatted data, or a store ACK.
- Handles both single-beat requests (non-cacheable or sub-line) and full cache-line fills.

Parameters:
- LINE_WIDTH, 128: dcache line width in bits; must be a multiple of 64, minimum 64.
- ADDR_WIDTH, 64: physical address width.
- TID_WIDTH, 2: transaction ID width.
- BEATS, LINE_WIDTH/64: derived; number of 64-bit beats per cache line.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_vld_i  in  1  dcache memory request valid; held until acked.
- req_ack_o  out  1  request accepted this cycle.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  3  0 byte, 1 half, 2 word, 3 dword, 7 cache line.
- req_nc_i  in  1  non-cacheable; forces a single beat.
- req_paddr_i  in  ADDR_WIDTH  physical address.
- req_wdata_i  in  64  store data, already byte-lane aligned.
- req_tid_i  in  TID_WIDTH  transaction ID.
- abort_i  in  1  requester abandoned the in-flight load.
- rtrn_vld_o  out  1  return packet valid, one cycle.
- rtrn_store_o  out  1  1 = store ACK, 0 = load ACK.
- rtrn_tid_o  out  TID_WIDTH  echoed TID.
- rtrn_data_o  out  LINE_WIDTH  load return line.
- mem_req_o  out  1  bus request.
- mem_gnt_i  in  1  bus grant.
- mem_we_o  out  1  bus write.
- mem_be_o  out  8  byte enables.
- mem_addr_o  out  ADDR_WIDTH  beat address.
- mem_wdata_o  out  64  write data.
- mem_rvalid_i  in  1  response for the granted beat; also sent for writes.
- mem_rdata_i  in  64  read data.

Behaviour:
- Reset (rst_i sampled high at a clock edge): state IDLE. Outputs req_ack_o, rtrn_vld_o, mem_req_o, mem_we_o = 0. Data, address, and be outputs plus the line buffer = 0. abort flag = 0.
- Reset mid-operation: the transaction is dropped without a return packet. Bus responses arriving afterwards are ignored in IDLE.

States:
- IDLE:
  - req_ack_o = req_vld_i, combinational, same cycle.
  - On ack, register we, size, nc, paddr, wdata, tid.
  - Compute beat count: BEATS if size == 7 and !nc and !we; otherwise 1.
  - Clear the line buffer and the abort flag. Go to ISSUE.
- ISSUE:
  - mem_req_o = 1, held until mem_gnt_i. On gnt, go to WAIT_RSP.
  - Single beat: mem_addr_o = paddr.
  - Line: mem_addr_o = {paddr line-aligned} + 8*k, where k is the beat counter.
  - Byte enables for single beat, with off = paddr[2:0]: byte 0x01<<off, half 0x03<<off, word 0x0F<<off, dword 0xFF. Line beats use 0xFF.
  - A store with size 7 is treated as dword.
- WAIT_RSP:
  - mem_rvalid_i is never accepted in the same cycle as its gnt; it arrives at least one cycle later.
  - On rvalid, a load writes mem_rdata_i into line lane L:
    - line beats: L = k;
    - single beat: L = paddr[log2(LINE_WIDTH/8)-1:3], other lanes stay 0.
  - If k < beats-1: k++ and go to ISSUE. Otherwise go to RETURN.
- RETURN:
  - rtrn_vld_o = 1 for exactly one cycle, unless the abort flag is set.
  - rtrn_store_o = we. rtrn_tid_o = tid. rtrn_data_o = line buffer (0 for stores).
  - Go to IDLE.

Abort:
- abort_i sampled high in any non-IDLE state while the transaction is a load sets a sticky abort flag.
- The bus transaction still completes all beats; only rtrn_vld_o is suppressed.
- abort_i is ignored for stores and in IDLE.

Handshake and latency:
- req_ack_o is never asserted outside IDLE, so back-to-back requests are serialized.
- Minimum single-beat latency from ack cycle T: gnt at T+1, rvalid at T+2, rtrn_vld at T+3.
- Beat counter k width is max(1, log2(BEATS)); it wraps only by the reset to 0 in IDLE.

Test Plan:
- Load dword, nc=1, paddr 0x8000_0008, gnt and rvalid at the earliest cycle, rdata 0xDEAD_BEEF_0123_4567 -> mem_be_o 0xFF, mem_addr_o 0x8000_0008, rtrn_vld 3 cycles after ack, rtrn_data = {0xDEADBEEF01234567, 64'h0}, rtrn_store 0.
- Line load, size 7, nc=0, paddr 0x8000_0018, rdata beats 0x11 then 0x22 -> addresses 0x8000_0010 then 0x8000_0018, rtrn_data = {64'h22, 64'h11}, one rtrn_vld pulse.
- Store half, paddr 0x1006, wdata 0xABCD_0000_0000_0000, gnt delayed 4 cycles -> mem_req_o held 5 cycles, mem_we 1, be 0xC0, rtrn_store 1, tid echoed.
- Load with abort_i pulsed during WAIT_RSP -> bus beat completes, no rtrn_vld. Next request acked only after the return to IDLE.
- req_vld_i held high while busy -> req_ack_o stays 0 until IDLE. rst_i asserted during a line load between beats -> next cycle mem_req_o 0, IDLE, and a stale rvalid produces no return.

Source files
------------

// File: rtl/riscmakers_dcache_mem_bridge_if.sv
// Channel bundles for the dcache-to-memory bridge: the dcache request/return
// side and the single-outstanding 64-bit memory bus side.

interface riscmakers_dcache_req_if #(
    parameter int LINE_WIDTH = 128,
    parameter int ADDR_WIDTH = 64,
    parameter int TID_WIDTH  = 2
);
    logic                  req_vld;
    logic                  req_ack;
    logic                  req_we;
    logic [2:0]            req_size;
    logic                  req_nc;
    logic [ADDR_WIDTH-1:0] req_paddr;
    logic [63:0]           req_wdata;
    logic [TID_WIDTH-1:0]  req_tid;
    logic                  abort;
    logic                  rtrn_vld;
    logic                  rtrn_store;
    logic [TID_WIDTH-1:0]  rtrn_tid;
    logic [LINE_WIDTH-1:0] rtrn_data;

    // master = dcache, slave = bridge
    modport master (
        output req_vld, req_we, req_size, req_nc, req_paddr, req_wdata, req_tid, abort,
        input  req_ack, rtrn_vld, rtrn_store, rtrn_tid, rtrn_data
    );
    modport slave (
        input  req_vld, req_we, req_size, req_nc, req_paddr, req_wdata, req_tid, abort,
        output req_ack, rtrn_vld, rtrn_store, rtrn_tid, rtrn_data
    );
endinterface

interface riscmakers_mem_bus_if #(
    parameter int ADDR_WIDTH = 64
);
    logic                  req;
    logic                  gnt;
    logic                  we;
    logic [7:0]            be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [63:0]           wdata;
    logic                  rvalid;
    logic [63:0]           rdata;

    // master = bridge, slave = memory
    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );
    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/riscmakers_dcache_mem_bridge.sv
// Serves dcache memory requests over a single-outstanding 64-bit bus, splitting
// line fills into beats and returning one line-formatted packet per request.

module riscmakers_dcache_mem_bridge #(
    parameter int LINE_WIDTH = 128,
    parameter int ADDR_WIDTH = 64,
    parameter int TID_WIDTH  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    riscmakers_dcache_req_if.slave  dc,
    riscmakers_mem_bus_if.master    mem
);
    localparam int BEATS = LINE_WIDTH / 64;
    localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((LINE_WIDTH / 8) - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RETURN} state_e;

    state_e                state_q, state_d;
    logic                  we_q;
    logic [2:0]            size_q;
    logic                  nc_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [63:0]           wdata_q;
    logic [TID_WIDTH-1:0]  tid_q;
    logic                  line_mode_q;
    logic [KW-1:0]         k_q;
    logic                  abort_q;
    logic [LINE_WIDTH-1:0] line_q;

    logic                  last_beat;
    logic [KW-1:0]         lane;
    logic [7:0]            be;
    logic [ADDR_WIDTH-1:0] beat_addr;

    assign last_beat = !line_mode_q || (k_q == KW'(BEATS - 1));
    // Single beats land in the lane their address selects within the line.
    assign lane      = line_mode_q ? k_q : ((BEATS > 1) ? paddr_q[3 +: KW] : '0);
    assign beat_addr = line_mode_q ? ((paddr_q & LINE_MASK) + ADDR_WIDTH'({k_q, 3'b000}))
                                   : paddr_q;

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignment so every register
        // samples pre-edge values regardless of statement order.
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_d
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:     if (dc.req_vld) state_d = ISSUE;
            ISSUE:    if (mem.gnt)    state_d = WAIT_RSP;
            WAIT_RSP: if (mem.rvalid) state_d = last_beat ? RETURN : ISSUE;
            RETURN:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        be = 8'hFF;
        if (!line_mode_q) begin
            case (size_q)
                3'd0:    be = 8'h01 << paddr_q[2:0];
                3'd1:    be = 8'h03 << paddr_q[2:0];
                3'd2:    be = 8'h0F << paddr_q[2:0];
                default: be = 8'hFF;
            endcase
        end
    end

    // NOTE: the line buffer is plain flops (not a RAM), so it takes the reset
    // like any other register and is also cleared on every accepted request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q        <= 1'b0;
            size_q      <= '0;
            nc_q        <= 1'b0;
            paddr_q     <= '0;
            wdata_q     <= '0;
            tid_q       <= '0;
            line_mode_q <= 1'b0;
            k_q         <= '0;
            abort_q     <= 1'b0;
            line_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dc.req_vld) begin
                        we_q        <= dc.req_we;
                        size_q      <= dc.req_size;
                        nc_q        <= dc.req_nc;
                        paddr_q     <= dc.req_paddr;
                        wdata_q     <= dc.req_wdata;
                        tid_q       <= dc.req_tid;
                        line_mode_q <= (dc.req_size == 3'd7) && !dc.req_nc && !dc.req_we;
                        k_q         <= '0;
                        abort_q     <= 1'b0;
                        line_q      <= '0;
                    end
                end
                WAIT_RSP: begin
                    if (mem.rvalid) begin
                        if (!we_q)      line_q[{lane, 6'b0} +: 64] <= mem.rdata;
                        if (!last_beat) k_q <= k_q + KW'(1);
                    end
                end
                default: ;
            endcase
            // Abort only silences the return; the bus beats still run out.
            if (state_q != IDLE && dc.abort && !we_q) abort_q <= 1'b1;
        end
    end

    assign dc.req_ack    = (state_q == IDLE) && dc.req_vld;
    assign dc.rtrn_vld   = (state_q == RETURN) && !abort_q;
    assign dc.rtrn_store = we_q;
    assign dc.rtrn_tid   = tid_q;
    assign dc.rtrn_data  = line_q;

    assign mem.req   = (state_q == ISSUE);
    assign mem.we    = (state_q == ISSUE) && we_q;
    assign mem.be    = (state_q == ISSUE) ? be        : '0;
    assign mem.addr  = (state_q == ISSUE) ? beat_addr : '0;
    assign mem.wdata = (state_q == ISSUE) ? wdata_q   : '0;

    // nc only shapes the beat count at accept time; kept for debug visibility.
    logic unused_nc;
    assign unused_nc = nc_q;
endmodule
